// File: rtl/instr_mem_loader.sv
// Instruction memory for the 8-bit core: a combinational fetch port plus a byte-stream
// load port. The memory stays hidden (NOPs served) until a load commits.
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 2 ** ADDR_W,
  parameter logic [7:0]  NOP_INSTR = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              loading,
  output logic [ADDR_W:0]   prog_len
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   prog_len_q;
  logic              ld_err_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              loading_q;
  logic              beat;

  logic [7:0] mem [DEPTH];

  // ld_ready_q is high exactly while in StLoad, so it doubles as the load qualifier.
  assign beat = ld_valid && ld_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      len_q      <= '0;
      prog_len_q <= '0;
      ld_err_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      loading_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ld_start) begin
            state_q    <= StLoad;
            wptr_q     <= '0;
            prog_len_q <= '0;
            ld_err_q   <= 1'b0;
            ld_ready_q <= 1'b1;
            loading_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (beat) begin
            wptr_q <= wptr_q + 1'b1;
            // Either an explicit last beat or the final slot ends the load.
            if (ld_last || (wptr_q == LastAddr)) begin
              state_q    <= StCommit;
              len_q      <= {1'b0, wptr_q} + 1'b1;
              ld_err_q   <= !ld_last;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        StCommit: begin
          state_q    <= StIdle;
          prog_len_q <= len_q;
          ld_done_q  <= 1'b0;
          loading_q  <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          ld_ready_q <= 1'b0;
          ld_done_q  <= 1'b0;
          loading_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; prog_len gates visibility.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wptr_q] <= ld_data;
    end
  end

  always_comb begin
    instr = NOP_INSTR;
    if ((state_q == StIdle) && ({1'b0, pc} < prog_len_q)) begin
      instr = mem[pc];
    end
  end

  assign ld_ready = ld_ready_q;
  assign ld_done  = ld_done_q;
  assign ld_err   = ld_err_q;
  assign loading  = loading_q;
  assign prog_len = prog_len_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed vectors plus randomized loads
// compared against a transaction-level program model.
module tb_instr_mem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic [7:0]        instr;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic              loading;
  logic [ADDR_W:0]   prog_len;

  instr_mem_loader #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_INSTR(8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc      (pc),
    .instr   (instr),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_ready(ld_ready),
    .ld_done (ld_done),
    .ld_err  (ld_err),
    .loading (loading),
    .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed program image, length and error flag.
  logic [7:0] ref_mem [DEPTH];
  int         ref_len = 0;
  bit         ref_err = 1'b0;

  logic [7:0] stim_q[$];
  int         gap_q[$];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] exp;
  } fetch_vec_t;

  fetch_vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fetch_chk(input logic [7:0] a, input string nm);
    logic [7:0] e;
    e = (int'(a) < ref_len) ? ref_mem[a] : 8'h00;
    @(negedge clk);
    pc       = a;
    ld_start = 1'b0;
    ld_valid = 1'($urandom);
    ld_data  = 8'($urandom);
    ld_last  = 1'($urandom);
    #1;
    check(nm, 32'(instr), 32'(e));
    check({nm, "_ready"}, 32'(ld_ready), 0);
    check({nm, "_len"}, 32'(prog_len), 32'(ref_len));
    check({nm, "_err"}, 32'(ld_err), 32'(ref_err));
  endtask

  // Streams stim_q; with use_last=0 exactly DEPTH beats are sent and overflow is expected.
  task automatic run_load(input bit use_last, input bit noise);
    int n;
    n = use_last ? stim_q.size() : DEPTH;
    @(negedge clk);
    ld_start = 1'b1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    pc       = noise ? 8'h00 : 8'($urandom);
    #1;
    check("start_ready", 32'(ld_ready), 0);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        ld_start = noise ? 1'($urandom) : 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'($urandom);
        ld_data  = 8'($urandom);
        pc       = noise ? 8'h00 : 8'($urandom);
        #1;
        check("gap_ready", 32'(ld_ready), 1);
        check("gap_instr", 32'(instr), 0);
        check("gap_len", 32'(prog_len), 0);
      end
      @(negedge clk);
      ld_start = noise && (i == 1);
      ld_valid = 1'b1;
      ld_data  = stim_q[i];
      ld_last  = use_last && (i == n - 1);
      pc       = noise ? 8'h00 : 8'($urandom);
      #1;
      check("beat_ready", 32'(ld_ready), 1);
      check("beat_loading", 32'(loading), 1);
      check("beat_instr", 32'(instr), 0);
      check("beat_len", 32'(prog_len), 0);
      check("beat_err", 32'(ld_err), 0);
      check("beat_done", 32'(ld_done), 0);
      ref_mem[i] = stim_q[i];
    end
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_last  = 1'b0;
    pc       = 8'h00;
    #1;
    check("commit_done", 32'(ld_done), 1);
    check("commit_ready", 32'(ld_ready), 0);
    check("commit_loading", 32'(loading), 1);
    check("commit_instr", 32'(instr), 0);
    ref_len = n;
    ref_err = !use_last;
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    check("post_done", 32'(ld_done), 0);
    check("post_loading", 32'(loading), 0);
    check("post_len", 32'(prog_len), 32'(ref_len));
    check("post_err", 32'(ld_err), 32'(ref_err));
    stim_q.delete();
    gap_q.delete();
  endtask

  task automatic table_chk(input string nm);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pc       = tbl[i].pc;
      ld_valid = 1'($urandom);
      #1;
      check(nm, 32'(instr), 32'(tbl[i].exp));
    end
  endtask

  initial begin
    tbl[0] = '{pc: 8'h00, exp: 8'h11};
    tbl[1] = '{pc: 8'h01, exp: 8'h22};
    tbl[2] = '{pc: 8'h02, exp: 8'h33};
    tbl[3] = '{pc: 8'h03, exp: 8'h00};
    tbl[4] = '{pc: 8'hFF, exp: 8'h00};
    tbl[5] = '{pc: 8'h80, exp: 8'h00};

    // Reset state and empty-memory sweep.
    @(negedge clk);
    #1;
    check("rst_ready", 32'(ld_ready), 0);
    check("rst_done", 32'(ld_done), 0);
    check("rst_err", 32'(ld_err), 0);
    check("rst_loading", 32'(loading), 0);
    check("rst_instr", 32'(instr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      pc       = 8'(a);
      ld_valid = 1'($urandom);
      #1;
      check("sweep_instr", 32'(instr), 0);
    end
    check("sweep_len", 32'(prog_len), 0);
    check("sweep_ready", 32'(ld_ready), 0);

    // Back-to-back three-byte load.
    stim_q = '{8'h11, 8'h22, 8'h33};
    run_load(1'b1, 1'b0);
    table_chk("b2b_tbl");

    // Same program with gapped valid.
    stim_q = '{8'h11, 8'h22, 8'h33};
    gap_q  = '{0, 2, 1};
    run_load(1'b1, 1'b0);
    table_chk("gap_tbl");

    // Redundant ld_start pulses during the load, pc held at 0.
    stim_q = '{8'h11, 8'h22, 8'h33};
    gap_q  = '{1, 1, 2};
    run_load(1'b1, 1'b1);
    table_chk("noise_tbl");

    // Overflow: DEPTH beats, data = index, no ld_last.
    for (int i = 0; i < DEPTH; i++) stim_q.push_back(8'(i));
    run_load(1'b0, 1'b0);
    fetch_chk(8'hFF, "ovf_ff");
    fetch_chk(8'h00, "ovf_00");
    fetch_chk(8'h7A, "ovf_7a");

    // Randomized loads against the model.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        stim_q.push_back(8'($urandom));
        gap_q.push_back($urandom_range(0, 2));
      end
      run_load(1'b1, 1'($urandom));
      for (int k = 0; k < 20; k++) fetch_chk(8'($urandom_range(0, len + 5)), "rand_fetch");
    end

    // Reset in the middle of a load.
    stim_q = '{8'hAA, 8'hBB};
    run_load(1'b1, 1'b0);
    fetch_chk(8'h01, "pre_rst_fetch");
    stim_q = '{8'hC1, 8'hC2, 8'hC3};
    @(negedge clk);
    ld_start = 1'b1;
    #1;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'hC1;
    ld_last  = 1'b0;
    #1;
    check("mid_ready", 32'(ld_ready), 1);
    @(negedge clk);
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    pc       = 8'h00;
    #1;
    ref_len = 0;
    ref_err = 1'b0;
    check("midrst_instr", 32'(instr), 0);
    check("midrst_len", 32'(prog_len), 0);
    check("midrst_ready", 32'(ld_ready), 0);
    check("midrst_loading", 32'(loading), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_chk(8'h00, "after_rst0");
    fetch_chk(8'h01, "after_rst1");
    run_load(1'b1, 1'b0);
    for (int a = 0; a < 5; a++) fetch_chk(8'(a), "reload_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
